// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: tags each accepted instruction with a
// unique major ID, queues it in a small FIFO and presents it through a stall-aware output register.
module fetch_queue #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int queueDepth              = 4
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               flush_i,
    input  logic                               enable_i,
    input  logic [instructionWidth-1:0]        instruction_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 instructionPid_i,
    input  logic [TidSize-1:0]                 instructionTid_i,
    input  logic                               stall_i,
    output logic                               stall_o,
    output logic                               enable_o,
    output logic [instructionWidth-1:0]        instruction_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic                               is64Bit_o,
    output logic [PidSize-1:0]                 instructionPid_o,
    output logic [TidSize-1:0]                 instructionTid_o,
    output logic [instructionCounterWidth-1:0] instructionMajId_o,
    output logic [$clog2(queueDepth):0]        count_o
);

    localparam int ptrWidth = $clog2(queueDepth);
    localparam logic [ptrWidth:0] fullCount = (ptrWidth + 1)'(queueDepth);

    typedef struct packed {
        logic [instructionWidth-1:0]        instruction;
        logic [addressWidth-1:0]            address;
        logic                               is64Bit;
        logic [PidSize-1:0]                 pid;
        logic [TidSize-1:0]                 tid;
        logic [instructionCounterWidth-1:0] majId;
    } queueEntry_t;

    queueEntry_t                        entryMem [queueDepth];
    queueEntry_t                        outReg;
    queueEntry_t                        newEntry;
    logic [ptrWidth-1:0]                wrPtr;
    logic [ptrWidth-1:0]                rdPtr;
    logic [ptrWidth:0]                  count;
    logic [instructionCounterWidth-1:0] majCounter;
    logic                               outValid;
    logic                               push;
    logic                               pop;
    logic                               loadOut;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot for a push.
    assign stall_o = (count == fullCount);
    assign push    = enable_i && !stall_o && !flush_i;
    assign loadOut = !stall_i || !outValid;
    assign pop     = loadOut && (count != '0) && !flush_i;

    always_comb begin
        newEntry.instruction = instruction_i;
        newEntry.address     = instructionAddress_i;
        newEntry.is64Bit     = is64Bit_i;
        newEntry.pid         = instructionPid_i;
        newEntry.tid         = instructionTid_i;
        newEntry.majId       = majCounter;
    end

    // NOTE: the storage array has no reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clock_i) begin
        if (push) begin
            entryMem[wrPtr] <= newEntry;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            majCounter <= '0;
        end else begin
            // The ID counter survives flushes so IDs stay unique.
            if (push) begin
                majCounter <= majCounter + instructionCounterWidth'(1);
            end
            if (flush_i) begin
                wrPtr <= '0;
                rdPtr <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    wrPtr <= wrPtr + ptrWidth'(1);
                end
                if (pop) begin
                    rdPtr <= rdPtr + ptrWidth'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + (ptrWidth + 1)'(1);
                    2'b01:   count <= count - (ptrWidth + 1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            outReg   <= '0;
            outValid <= 1'b0;
        end else if (flush_i) begin
            outValid <= 1'b0;
        end else if (loadOut) begin
            // Data fields keep their last value when a bubble is loaded.
            if (count != '0) begin
                outReg   <= entryMem[rdPtr];
                outValid <= 1'b1;
            end else begin
                outValid <= 1'b0;
            end
        end
    end

    assign enable_o             = outValid;
    assign instruction_o        = outReg.instruction;
    assign instructionAddress_o = outReg.address;
    assign is64Bit_o            = outReg.is64Bit;
    assign instructionPid_o     = outReg.pid;
    assign instructionTid_o     = outReg.tid;
    assign instructionMajId_o   = outReg.majId;
    assign count_o              = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue: reset, latency, back-pressure,
// streaming, flush and stall-hold scenarios with hand-computed expectations.
module tb_fetch_queue;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        flush_i;
    logic        enable_i;
    logic [31:0] instruction_i;
    logic [63:0] instructionAddress_i;
    logic        is64Bit_i;
    logic [19:0] instructionPid_i;
    logic [15:0] instructionTid_i;
    logic        stall_i;
    logic        stall_o;
    logic        enable_o;
    logic [31:0] instruction_o;
    logic [63:0] instructionAddress_o;
    logic        is64Bit_o;
    logic [19:0] instructionPid_o;
    logic [15:0] instructionTid_o;
    logic [63:0] instructionMajId_o;
    logic [2:0]  count_o;

    int total = 0;
    int bad   = 0;

    fetch_queue dut (
        .clock_i              (clock_i),
        .reset_i              (reset_i),
        .flush_i              (flush_i),
        .enable_i             (enable_i),
        .instruction_i        (instruction_i),
        .instructionAddress_i (instructionAddress_i),
        .is64Bit_i            (is64Bit_i),
        .instructionPid_i     (instructionPid_i),
        .instructionTid_i     (instructionTid_i),
        .stall_i              (stall_i),
        .stall_o              (stall_o),
        .enable_o             (enable_o),
        .instruction_o        (instruction_o),
        .instructionAddress_o (instructionAddress_o),
        .is64Bit_o            (is64Bit_o),
        .instructionPid_o     (instructionPid_o),
        .instructionTid_o     (instructionTid_o),
        .instructionMajId_o   (instructionMajId_o),
        .count_o              (count_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic drivePush(input logic en, input int id);
        enable_i             = en;
        instruction_i        = 32'hA000_0000 + 32'(id);
        instructionAddress_i = 64'h2000 + 64'(id) * 64'd4;
        is64Bit_i            = id[0];
        instructionPid_i     = 20'(id + 100);
        instructionTid_i     = 16'(id + 7);
    endtask

    // Asynchronous reset pulse placed mid-cycle, away from any clock edge.
    task automatic pulseReset();
        #3;
        reset_i = 1'b0;
        #1;
        check("rst_enable", 64'(enable_o), 64'd0);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        #1;
        reset_i = 1'b1;
    endtask

    initial begin
        reset_i  = 1'b0;
        flush_i  = 1'b0;
        stall_i  = 1'b0;
        drivePush(1'b0, 0);
        #2;
        check("init_enable", 64'(enable_o), 64'd0);
        check("init_count", 64'(count_o), 64'd0);
        check("init_stall", 64'(stall_o), 64'd0);
        check("init_majid", instructionMajId_o, 64'd0);
        check("init_instr", 64'(instruction_o), 64'd0);
        #1;
        reset_i = 1'b1;
        step();

        // Latency and tagging
        enable_i             = 1'b1;
        instruction_i        = 32'h7C08_02A6;
        instructionAddress_i = 64'h1000;
        is64Bit_i            = 1'b1;
        instructionPid_i     = 20'h12345;
        instructionTid_i     = 16'hBEEF;
        step();
        enable_i = 1'b0;
        check("lat_e1_enable", 64'(enable_o), 64'd0);
        check("lat_e1_count", 64'(count_o), 64'd1);
        step();
        check("lat_e2_enable", 64'(enable_o), 64'd1);
        check("lat_e2_instr", 64'(instruction_o), 64'h7C08_02A6);
        check("lat_e2_addr", instructionAddress_o, 64'h1000);
        check("lat_e2_majid", instructionMajId_o, 64'd0);
        check("lat_e2_is64", 64'(is64Bit_o), 64'd1);
        check("lat_e2_pid", 64'(instructionPid_o), 64'h12345);
        check("lat_e2_tid", 64'(instructionTid_o), 64'hBEEF);
        check("lat_e2_count", 64'(count_o), 64'd0);
        step();
        check("lat_e3_enable", 64'(enable_o), 64'd0);

        // Full and back-pressure
        pulseReset();
        step();
        stall_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drivePush(1'b1, i);
            step();
            if (i == 4) begin
                check("full_count5", 64'(count_o), 64'd4);
                check("full_stall5", 64'(stall_o), 64'd1);
            end
        end
        drivePush(1'b0, 0);
        check("full_count6", 64'(count_o), 64'd4);
        check("full_stall6", 64'(stall_o), 64'd1);
        check("full_head_enable", 64'(enable_o), 64'd1);
        check("full_head_majid", instructionMajId_o, 64'd0);
        stall_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("drain_enable", 64'(enable_o), 64'd1);
            check("drain_majid", instructionMajId_o, 64'(i));
            check("drain_instr", 64'(instruction_o), 64'hA000_0000 + 64'(i));
        end
        check("drain_stall", 64'(stall_o), 64'd0);
        step();
        check("drain_bubble", 64'(enable_o), 64'd0);
        drivePush(1'b1, 5);
        step();
        drivePush(1'b0, 0);
        step();
        check("rejected_not_consumed", instructionMajId_o, 64'd5);

        // Reset mid-run with three entries queued
        pulseReset();
        step();
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drivePush(1'b1, i);
            step();
        end
        drivePush(1'b0, 0);
        check("pre_rst_count", 64'(count_o), 64'd3);
        check("pre_rst_enable", 64'(enable_o), 64'd1);
        #3;
        reset_i = 1'b0;
        #1;
        check("mid_rst_enable", 64'(enable_o), 64'd0);
        check("mid_rst_count", 64'(count_o), 64'd0);
        check("mid_rst_stall", 64'(stall_o), 64'd0);
        check("mid_rst_instr", 64'(instruction_o), 64'd0);
        check("mid_rst_addr", instructionAddress_o, 64'd0);
        check("mid_rst_majid", instructionMajId_o, 64'd0);
        check("mid_rst_pid", 64'(instructionPid_o), 64'd0);
        #1;
        reset_i = 1'b1;
        stall_i = 1'b0;
        step();
        drivePush(1'b1, 9);
        step();
        drivePush(1'b0, 0);
        step();
        check("post_rst_enable", 64'(enable_o), 64'd1);
        check("post_rst_majid", instructionMajId_o, 64'd0);

        // Streaming
        pulseReset();
        step();
        stall_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drivePush(1'b1, k);
            step();
            if (k >= 1) begin
                check("stream_enable", 64'(enable_o), 64'd1);
                check("stream_majid", instructionMajId_o, 64'(k - 1));
            end
            check("stream_count_le1", 64'(count_o <= 3'd1), 64'd1);
            check("stream_stall", 64'(stall_o), 64'd0);
        end
        drivePush(1'b0, 0);
        step();
        check("stream_last_enable", 64'(enable_o), 64'd1);
        check("stream_last_majid", instructionMajId_o, 64'd9);
        step();
        check("stream_end_enable", 64'(enable_o), 64'd0);

        // Flush with a simultaneous push; counter is at 10 here
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drivePush(1'b1, 10 + i);
            step();
        end
        check("pre_flush_count", 64'(count_o), 64'd3);
        check("pre_flush_enable", 64'(enable_o), 64'd1);
        check("pre_flush_majid", instructionMajId_o, 64'd10);
        drivePush(1'b1, 20);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        drivePush(1'b0, 0);
        check("flush_enable", 64'(enable_o), 64'd0);
        check("flush_count", 64'(count_o), 64'd0);
        stall_i = 1'b0;
        drivePush(1'b1, 21);
        step();
        drivePush(1'b0, 0);
        step();
        check("post_flush_enable", 64'(enable_o), 64'd1);
        check("post_flush_majid", instructionMajId_o, 64'd14);

        // Stall hold
        pulseReset();
        step();
        stall_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drivePush(1'b1, i);
            step();
        end
        drivePush(1'b0, 0);
        check("hold_start_majid", instructionMajId_o, 64'd2);
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("hold_enable", 64'(enable_o), 64'd1);
            check("hold_majid", instructionMajId_o, 64'd2);
            check("hold_instr", 64'(instruction_o), 64'hA000_0002);
            check("hold_addr", instructionAddress_o, 64'h2008);
        end
        stall_i = 1'b0;
        step();
        check("release_enable", 64'(enable_o), 64'd1);
        check("release_majid", instructionMajId_o, 64'd3);
        check("release_tid", 64'(instructionTid_o), 64'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
